alu_issue_ctrl: RTL and testbench

- Sequencer directly upstream of the 32-bit ALU.
- Accepts one operation per valid/ready request, latches the operands and drives them stable into the ALU.
- Waits for the ALU `done` (single-cycle logic ops, multi-cycle MUL/DIV), captures result/sub_reg_result/flag, and returns them on a valid/ready response channel.
- Also guarantees the ALU sees an idle opcode between operations so stale `done` levels are never sampled.

---
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Single-outstanding sequencer in front of the 32-bit ALU: IDLE -> ISSUE -> WAIT -> RESP.
// Optional watchdog on the WAIT state is compiled in with ALU_WATCHDOG_EN.
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LAT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_num_1,
  input  logic [WIDTH-1:0] req_num_2,
  input  logic [WIDTH-1:0] req_sub,
  output logic [WIDTH-1:0] alu_num_1,
  output logic [WIDTH-1:0] alu_num_2,
  output logic [WIDTH-1:0] alu_sub_reg_input,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_sub_reg_result,
  input  logic             alu_done,
  input  logic [3:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_sub,
  output logic [3:0]       rsp_flag,
  output logic [LAT_W-1:0] rsp_latency,
`ifdef ALU_WATCHDOG_EN
  output logic             rsp_timeout,
`endif
  output logic             rsp_illegal
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

`ifdef ALU_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] lat_cnt, lat_inc;
  logic [WD_W-1:0]  wait_cnt;
  logic             illegal_op, wd_hit;

  assign lat_inc    = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;
  assign illegal_op = alu_opcode > 4'd8;
  // wait_cnt is constant-folded away when the watchdog is compiled out
  assign wd_hit     = WD_EN && !alu_done && (wait_cnt == WD_W'(TIMEOUT - 1));
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req_valid) state_nxt = ISSUE;
      ISSUE: state_nxt = illegal_op ? RESP : WAIT;
      WAIT:  if (alu_done || wd_hit) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_num_1         <= '0;
      alu_num_2         <= '0;
      alu_sub_reg_input <= '0;
      alu_opcode        <= 4'hF;
      lat_cnt           <= '0;
      wait_cnt          <= '0;
      rsp_result        <= '0;
      rsp_sub           <= '0;
      rsp_flag          <= '0;
      rsp_latency       <= '0;
      rsp_illegal       <= 1'b0;
`ifdef ALU_WATCHDOG_EN
      rsp_timeout       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          alu_num_1         <= req_num_1;
          alu_num_2         <= req_num_2;
          alu_sub_reg_input <= req_sub;
          alu_opcode        <= req_opcode;
          lat_cnt           <= '0;
          wait_cnt          <= '0;
        end
        ISSUE: begin
          // done is deliberately ignored here: it may still reflect the previous op
          lat_cnt <= lat_inc;
          if (illegal_op) begin
            rsp_result  <= '0;
            rsp_sub     <= '0;
            rsp_flag    <= 4'hF;
            rsp_latency <= lat_inc;
            rsp_illegal <= 1'b1;
`ifdef ALU_WATCHDOG_EN
            rsp_timeout <= 1'b0;
`endif
            alu_opcode  <= 4'hF;
          end
        end
        WAIT: begin
          lat_cnt  <= lat_inc;
          wait_cnt <= wait_cnt + 1'b1;
          if (alu_done) begin
            rsp_result  <= alu_result;
            rsp_sub     <= alu_sub_reg_result;
            rsp_flag    <= alu_flag;
            rsp_latency <= lat_inc;
            rsp_illegal <= 1'b0;
`ifdef ALU_WATCHDOG_EN
            rsp_timeout <= 1'b0;
`endif
            alu_opcode  <= 4'hF;
          end else if (wd_hit) begin
            rsp_result  <= '0;
            rsp_sub     <= '0;
            rsp_flag    <= 4'hF;
            rsp_latency <= lat_inc;
            rsp_illegal <= 1'b0;
`ifdef ALU_WATCHDOG_EN
            rsp_timeout <= 1'b1;
`endif
            alu_opcode  <= 4'hF;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl: emulated ALU plus a transaction/timeline model
// that predicts every controller output on every cycle.
module tb_alu_issue_ctrl;
  localparam int W  = 32;
  localparam int LW = 8;
`ifdef ALU_WATCHDOG_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0, reset = 1'b0;
  logic          req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [3:0]    req_opcode = '0, alu_opcode, alu_flag = '0, rsp_flag;
  logic [W-1:0]  req_num_1 = '0, req_num_2 = '0, req_sub = '0;
  logic [W-1:0]  alu_num_1, alu_num_2, alu_sub_reg_input;
  logic [W-1:0]  alu_result = '0, alu_sub_reg_result = '0, rsp_result, rsp_sub;
  logic          alu_done = 1'b0, rsp_illegal;
  logic [LW-1:0] rsp_latency;
`ifdef ALU_WATCHDOG_EN
  logic          rsp_timeout;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .LAT_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_num_1(req_num_1), .req_num_2(req_num_2), .req_sub(req_sub),
    .alu_num_1(alu_num_1), .alu_num_2(alu_num_2), .alu_sub_reg_input(alu_sub_reg_input),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_sub_reg_result(alu_sub_reg_result),
    .alu_done(alu_done), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_sub(rsp_sub),
    .rsp_flag(rsp_flag), .rsp_latency(rsp_latency),
`ifdef ALU_WATCHDOG_EN
    .rsp_timeout(rsp_timeout),
`endif
    .rsp_illegal(rsp_illegal)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU behaviour used both by the emulated ALU and the expected-value model
  function automatic void alu_fn(input logic [3:0] op, input logic [31:0] a, b, s,
                                 output logic [31:0] r, sr, output logic [3:0] f);
    logic [32:0] sum;
    logic [63:0] p;
    sum = '0; p = '0; r = a ^ b; sr = '0;
    case (op)
      4'd0: begin sum = {1'b0, a} + {1'b0, b}; r = sum[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); r = p[31:0]; sr = p[63:32]; end
      4'd3: if (b == 0) begin r = '1; sr = a; end
            else begin p = {s, a} / 64'(b); r = p[31:0]; p = {s, a} % 64'(b); sr = p[31:0]; end
      4'd5: r = a & b;
      default: ;
    endcase
    f = {1'b0, r == 0, r[31], 1'b0};
    if (op == 4'd0) f = {(a[31] == b[31]) && (r[31] != a[31]), r == 0, r[31], sum[32]};
  endfunction

  // Timeline model: one op in flight, response due at t_rsp, until handshake
  bit          busy = 0, glitch = 0, nxt_glitch = 0;
  longint      c = 0, t_acc = 0, t_rsp = 0;
  int          cur_dly = 1, nxt_dly = 1;
  logic [3:0]  m_op = '0, e_flag = '0;
  logic [31:0] m_a = '0, m_b = '0, m_s = '0, e_res = '0, e_sub = '0;
  logic [7:0]  e_lat = '0;
  logic        e_ill = 0, e_to = 0;
  int          k = 0;
  bit          prev = 0;

  task automatic check_cycle();
    bit exp_rv, in_flight;
    exp_rv    = busy && (c >= t_rsp);
    in_flight = busy && (c > t_acc) && (c < t_rsp);
    chk("req_ready", 64'(req_ready), 64'(!busy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("alu_opcode", 64'(alu_opcode), 64'(in_flight ? m_op : 4'hF));
    if (in_flight) begin
      chk("alu_num_1", 64'(alu_num_1), 64'(m_a));
      chk("alu_num_2", 64'(alu_num_2), 64'(m_b));
      chk("alu_sub_in", 64'(alu_sub_reg_input), 64'(m_s));
    end
    if (exp_rv) begin
      chk("rsp_result", 64'(rsp_result), 64'(e_res));
      chk("rsp_sub", 64'(rsp_sub), 64'(e_sub));
      chk("rsp_flag", 64'(rsp_flag), 64'(e_flag));
      chk("rsp_latency", 64'(rsp_latency), 64'(e_lat));
      chk("rsp_illegal", 64'(rsp_illegal), 64'(e_ill));
`ifdef ALU_WATCHDOG_EN
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
`endif
    end
  endtask

  // Emulated ALU: done rises cur_dly cycles after ISSUE and stays high while the op is driven
  task automatic alu_drive();
    if (alu_opcode != 4'hF) begin k = prev ? k + 1 : 0; prev = 1; end
    else begin k = 0; prev = 0; end
    alu_done = 1'b0;
    alu_result = $urandom; alu_sub_reg_result = $urandom; alu_flag = 4'($urandom);
    if (alu_opcode != 4'hF) begin
      if (k > 0 && k >= cur_dly) begin
        alu_done = 1'b1;
        alu_fn(alu_opcode, alu_num_1, alu_num_2, alu_sub_reg_input,
               alu_result, alu_sub_reg_result, alu_flag);
      end else if (k == 0 && glitch) alu_done = 1'b1;
    end
  endtask

  task automatic model_update();
    if (busy && c >= t_rsp && rsp_ready) busy = 0;
    else if (!busy && req_valid) begin
      busy = 1; t_acc = c; m_op = req_opcode;
      m_a = req_num_1; m_b = req_num_2; m_s = req_sub;
      cur_dly = nxt_dly; glitch = nxt_glitch; e_to = 0;
      if (m_op > 4'd8) begin
        t_rsp = c + 2; e_res = 0; e_sub = 0; e_flag = 4'hF; e_lat = 8'd1; e_ill = 1;
      end else begin
        e_ill = 0;
`ifdef ALU_WATCHDOG_EN
        if (cur_dly > TO) begin
          t_rsp = c + 2 + TO; e_res = 0; e_sub = 0; e_flag = 4'hF; e_lat = 8'(TO + 1); e_to = 1;
        end else
`endif
        begin
          t_rsp = c + 2 + cur_dly;
          alu_fn(m_op, m_a, m_b, m_s, e_res, e_sub, e_flag);
          e_lat = (cur_dly + 1 > 255) ? 8'd255 : 8'(cur_dly + 1);
        end
      end
    end
    c++;
  endtask

  task automatic step();
    check_cycle();
    alu_drive();
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_req();
    req_valid = 1'($urandom); req_opcode = 4'($urandom);
    req_num_1 = $urandom; req_num_2 = $urandom; req_sub = $urandom;
  endtask

  // Issues one op from IDLE, waits for the response, holds rsp_ready low for `hold` cycles
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, s, input int dly,
                       input int hold, input bit gl, output logic [31:0] r, sr,
                       output logic [3:0] f, output logic [7:0] lat, output logic il,
                       output int n);
    req_valid = 1; req_opcode = op; req_num_1 = a; req_num_2 = b; req_sub = s;
    nxt_dly = dly; nxt_glitch = gl; rsp_ready = 0;
    step();
    n = 1;
    while (!rsp_valid && n < 400) begin rand_req(); step(); n++; end
    n_chk++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_wait: no response after %0d cycles, required within 400", n);
    end
    r = rsp_result; sr = rsp_sub; f = rsp_flag; lat = rsp_latency; il = rsp_illegal;
    repeat (hold) begin rand_req(); step(); end
    rand_req(); req_valid = 1; rsp_ready = 1;
    step();
    rsp_ready = 0; req_valid = 0;
  endtask

  initial begin
    logic [31:0] r, sr;
    logic [3:0]  f, op;
    logic [7:0]  lat;
    logic        il;
    int          n;

    #1 reset = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'hF);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    do_op(4'd0, 32'd5, 32'd7, 32'd0, 1, 0, 0, r, sr, f, lat, il, n);
    chk("add_result", 64'(r), 64'd12);
    chk("add_flag", 64'(f), 64'd0);
    chk("add_latency", 64'(lat), 64'd2);
    chk("add_illegal", 64'(il), 64'd0);
    chk("add_rsp_cycle", 64'(n), 64'd3);

    do_op(4'd2, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 0, 1, r, sr, f, lat, il, n);
    chk("mul_sub", 64'(sr), 64'd1);
    chk("mul_result", 64'(r), 64'd0);
    chk("mul_latency", 64'(lat), 64'd34);
    chk("mul_rsp_cycle", 64'(n), 64'd35);

    do_op(4'hA, $urandom, $urandom, $urandom, 5, 0, 1, r, sr, f, lat, il, n);
    chk("ill_result", 64'(r), 64'd0);
    chk("ill_flag", 64'(f), 64'hF);
    chk("ill_illegal", 64'(il), 64'd1);
    chk("ill_rsp_cycle", 64'(n), 64'd2);

    do_op(4'd5, 32'hF0F0, 32'h0FF0, 32'd0, 1, 5, 0, r, sr, f, lat, il, n);
    chk("and_result", 64'(r), 64'h00F0);

    // DIV interrupted by reset while in WAIT
    req_valid = 1; req_opcode = 4'd3; req_num_1 = 32'd1000; req_num_2 = 32'd7; req_sub = 0;
    nxt_dly = 20; nxt_glitch = 0;
    step();
    req_valid = 0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_req_ready", 64'(req_ready), 64'd1);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_alu_opcode", 64'(alu_opcode), 64'hF);
    chk("arst_alu_num_1", 64'(alu_num_1), 64'd0);
    chk("arst_rsp_result", 64'(rsp_result), 64'd0);
    chk("arst_rsp_flag", 64'(rsp_flag), 64'd0);
    chk("arst_rsp_latency", 64'(rsp_latency), 64'd0);
    busy = 0; prev = 0; k = 0; alu_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_op(4'd0, 32'd100, 32'd23, 32'd0, 1, 0, 0, r, sr, f, lat, il, n);
    chk("post_rst_add", 64'(r), 64'd123);

`ifdef ALU_WATCHDOG_EN
    do_op(4'd1, $urandom, $urandom, 32'd0, 100000, 0, 0, r, sr, f, lat, il, n);
    chk("wd_flag", 64'(f), 64'hF);
    chk("wd_latency", 64'(lat), 64'd11);
    chk("wd_rsp_cycle", 64'(n), 64'd12);
`else
    do_op(4'd1, $urandom, $urandom, 32'd0, 300, 0, 0, r, sr, f, lat, il, n);
    chk("sat_latency", 64'(lat), 64'd255);
    chk("sat_rsp_cycle", 64'(n), 64'd302);
`endif

    repeat (300) begin
      repeat ($urandom_range(0, 2)) begin
        rand_req(); req_valid = 0; step();
      end
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      do_op(op, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 40),
            $urandom_range(0, 3), 1'($urandom), r, sr, f, lat, il, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
